frame_data_pipe: RTL and testbench
==================================

FRAME_DATA_PIPE -- requirements
Module: frame_data_pipe

Interface
REQ-001 SHALL have parameter FrameBitsPerRow, default 32, frame data width in bits.
REQ-002 SHALL have parameter RowSelectWidth, default 5, width of the row-select bus.
REQ-003 SHALL have parameter Row, default 1, row address this instance responds to.
REQ-004 SHALL have parameter PipeStages, default 2, legal 1..4, number of register stages from input to output.
REQ-005 SHALL have parameter BroadcastEn, default 0, when 1 an all-ones RowSelect also matches this row.
REQ-006 SHALL have port CLK  input  1  rising-edge clock.
REQ-007 SHALL have port RST  input  1  reset, synchronous, active-high.
REQ-008 SHALL have port FrameData_I  input  FrameBitsPerRow  incoming frame word.
REQ-009 SHALL have port RowSelect  input  RowSelectWidth  target row address.
REQ-010 SHALL have port FrameValid_I  input  1  qualifies FrameData_I/RowSelect this cycle.
REQ-011 SHALL have port FrameData_O  output  FrameBitsPerRow  last delivered frame word, held.
REQ-012 SHALL have port FrameValid_O  output  1  one-cycle pulse when FrameData_O updates.
REQ-013 SHALL have port FrameCount_O  output  16  saturating count of frames delivered.
REQ-014 SHALL have port Busy_O  output  1  high while any pipeline stage holds a valid frame.

Function
REQ-015 A frame SHALL be accepted when FrameValid_I=1 and (RowSelect==Row, or BroadcastEn=1 and RowSelect all-ones).
REQ-016 Stage 0 SHALL capture FrameData_I with valid bit set on accept; otherwise its valid bit SHALL clear and data is don't-care.
REQ-017 Stages 1..PipeStages-1 SHALL shift data and valid forward every cycle, unconditionally.
REQ-018 FrameData_O SHALL update only when the final stage's valid is 1; it SHALL otherwise hold its previous value.
REQ-019 Latency SHALL be exactly PipeStages cycles from accepting edge to FrameData_O/FrameValid_O update edge.
REQ-020 FrameValid_O SHALL pulse high for exactly one cycle per delivered frame; back-to-back accepts SHALL yield back-to-back pulses (throughput 1 frame/cycle).
REQ-021 FrameCount_O SHALL increment by 1 on each FrameValid_O pulse and saturate at 16'hFFFF.
REQ-022 Busy_O SHALL be the OR of all stage valid bits (combinational from registers).
REQ-023 Non-matching or unqualified cycles SHALL insert bubbles that never alter FrameData_O or FrameCount_O.

Reset
REQ-024 On RST=1 at a rising edge all stage valid bits, FrameValid_O, FrameCount_O SHALL clear to 0 and FrameData_O and stage data SHALL clear to all-zeros.
REQ-025 Reset SHALL take priority over accept; a frame presented during reset SHALL be discarded and frames in flight SHALL be lost.
REQ-026 First accept is possible on the first edge with RST=0.

Configuration
REQ-027 Macro FRAME_DATA_PIPE_PARITY_EN SHALL, when defined, add input FrameParity_I (1 bit, even parity over FrameData_I) and output ParityErr_O (1 bit).
REQ-028 With FRAME_DATA_PIPE_PARITY_EN, an accepted frame whose XOR(FrameData_I)^FrameParity_I=1 SHALL be dropped at stage 0 (valid not set) and ParityErr_O SHALL set sticky on the next edge, cleared only by RST.
REQ-029 Without FRAME_DATA_PIPE_PARITY_EN, FrameParity_I and ParityErr_O SHALL not exist and all accepted frames SHALL propagate.

Verification
REQ-030 Defaults, RST low; Row=1, FrameValid_I=1, FrameData_I=32'hDEADBEEF one cycle -> FrameData_O=32'hDEADBEEF and FrameValid_O pulse exactly 2 edges later, FrameCount_O=1.
REQ-031 PipeStages=4; 8 consecutive accepts 32'h1..32'h8 -> 8 consecutive FrameValid_O pulses starting 4 edges after first, data in order, FrameCount_O=8.
REQ-032 RowSelect=2 with FrameValid_I=1, then RowSelect=1 with FrameValid_I=0 -> no pulse, FrameData_O unchanged, Busy_O stays 0.
REQ-033 BroadcastEn=1, RowSelect=5'h1F, data 32'hA5A5A5A5 -> delivered; BroadcastEn=0 same stimulus -> not delivered.
REQ-034 Accept 32'h12345678, assert RST on next edge -> no FrameValid_O pulse, FrameData_O=0, FrameCount_O=0; preload count 16'hFFFE plus 3 frames -> FrameCount_O=16'hFFFF.
REQ-035 FRAME_DATA_PIPE_PARITY_EN defined; data 32'h00000001 with FrameParity_I=0 -> dropped, ParityErr_O=1 sticky; next frame 32'h00000003 parity 0 -> delivered, ParityErr_O remains 1.

Source files
------------

// File: rtl/frame_data_pipe.sv
// frame_data_pipe: row-addressed frame word delivery pipeline.
// A frame word is accepted when qualified and addressed to this row. It then
// travels through PipeStages register stages and updates the held output
// word with a one-cycle valid pulse. A saturating counter tracks deliveries.
// Optional feature macro: FRAME_DATA_PIPE_PARITY_EN adds an even-parity input.
// Frames that fail the parity check are dropped at stage 0, and a sticky
// error flag is raised.
//
// Handshake: valid-only, no backpressure. FrameValid_I qualifies
// FrameData_I/RowSelect in the cycle it is high. FrameValid_O marks the single
// cycle in which FrameData_O has just taken a new word. The pipeline never
// stalls, so a stage's contents always move forward on the next edge.
// PipeStages must be within 1..4.
module frame_data_pipe #(
  parameter int FrameBitsPerRow = 32,
  parameter int RowSelectWidth  = 5,
  parameter int Row             = 1,
  parameter int PipeStages      = 2,
  parameter bit BroadcastEn     = 1'b0
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic [FrameBitsPerRow-1:0] FrameData_I,
  input  logic [RowSelectWidth-1:0]  RowSelect,
  input  logic                       FrameValid_I,
`ifdef FRAME_DATA_PIPE_PARITY_EN
  input  logic                       FrameParity_I,
  output logic                       ParityErr_O,
`endif
  output logic [FrameBitsPerRow-1:0] FrameData_O,
  output logic                       FrameValid_O,
  output logic [15:0]                FrameCount_O,
  output logic                       Busy_O
);

  logic [FrameBitsPerRow-1:0] stage_data_q [PipeStages];
  logic [FrameBitsPerRow-1:0] stage_data_d [PipeStages];
  logic [PipeStages-1:0]      stage_vld_q;
  logic [PipeStages-1:0]      stage_vld_d;

  logic [FrameBitsPerRow-1:0] data_o_q, data_o_d;
  logic                       vld_o_q, vld_o_d;
  logic [15:0]                count_q, count_d;

  logic row_hit;
  logic accept;
  logic frame_ok;
  logic last_vld;

`ifdef FRAME_DATA_PIPE_PARITY_EN
  logic parity_bad;
  logic perr_q, perr_d;
`endif

  // Row match and qualification. Parity screening happens here when enabled.
  always_comb begin
    row_hit = (RowSelect == RowSelectWidth'(Row)) || (BroadcastEn && (&RowSelect));
    accept  = FrameValid_I && row_hit;
`ifdef FRAME_DATA_PIPE_PARITY_EN
    parity_bad = (^FrameData_I) ^ FrameParity_I;
    frame_ok   = accept && !parity_bad;
    perr_d     = perr_q || (accept && parity_bad);
`else
    frame_ok   = accept;
`endif
  end

  // Stage 0 captures the word on accept. Later stages shift forward every cycle.
  always_comb begin
    stage_data_d = stage_data_q;
    stage_vld_d  = '0;
    stage_vld_d[0] = frame_ok;
    if (frame_ok) begin
      stage_data_d[0] = FrameData_I;
    end
    for (int i = 1; i < PipeStages; i++) begin
      stage_vld_d[i]  = stage_vld_q[i-1];
      stage_data_d[i] = stage_data_q[i-1];
    end
  end

  // Output register updates only when the final stage holds a frame. The counter saturates.
  always_comb begin
    last_vld = stage_vld_q[PipeStages-1];
    data_o_d = last_vld ? stage_data_q[PipeStages-1] : data_o_q;
    vld_o_d  = last_vld;
    count_d  = (last_vld && (count_q != 16'hFFFF)) ? (count_q + 16'd1) : count_q;
  end

  // State registers. Reset overrides any accept and flushes frames in flight.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < PipeStages; i++) begin
        stage_data_q[i] <= '0;
      end
      stage_vld_q <= '0;
      data_o_q    <= '0;
      vld_o_q     <= 1'b0;
      count_q     <= '0;
    end else begin
      stage_data_q <= stage_data_d;
      stage_vld_q  <= stage_vld_d;
      data_o_q     <= data_o_d;
      vld_o_q      <= vld_o_d;
      count_q      <= count_d;
    end
  end

`ifdef FRAME_DATA_PIPE_PARITY_EN
  // Sticky parity error flag. Only reset clears it.
  always_ff @(posedge CLK) begin
    if (RST) begin
      perr_q <= 1'b0;
    end else begin
      perr_q <= perr_d;
    end
  end

  assign ParityErr_O = perr_q;
`endif

  assign FrameData_O  = data_o_q;
  assign FrameValid_O = vld_o_q;
  assign FrameCount_O = count_q;
  assign Busy_O       = |stage_vld_q;

endmodule

// File: tb/tb_frame_data_pipe.sv
// tb_frame_data_pipe: directed bench for frame_data_pipe.
// Three instances share one stimulus stream:
//   dut  - default parameters
//   dut4 - PipeStages=4
//   dutb - BroadcastEn=1
// Build with FRAME_DATA_PIPE_PARITY_EN defined to also exercise parity.
module tb_frame_data_pipe;

  logic        clk;
  logic        rst;
  logic [31:0] frame_data_i;
  logic [4:0]  row_select;
  logic        frame_valid_i;

  logic [31:0] data_o, data4, datab;
  logic        vld_o, vld4, vldb;
  logic [15:0] cnt_o, cnt4, cntb;
  logic        busy_o, busy4, busyb;

`ifdef FRAME_DATA_PIPE_PARITY_EN
  logic frame_parity_i;
  logic perr_o, perr4, perrb;
`endif

  int checks;
  int failures;

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  frame_data_pipe dut (
    .CLK(clk), .RST(rst), .FrameData_I(frame_data_i), .RowSelect(row_select),
    .FrameValid_I(frame_valid_i),
`ifdef FRAME_DATA_PIPE_PARITY_EN
    .FrameParity_I(frame_parity_i), .ParityErr_O(perr_o),
`endif
    .FrameData_O(data_o), .FrameValid_O(vld_o), .FrameCount_O(cnt_o), .Busy_O(busy_o)
  );

  frame_data_pipe #(.PipeStages(4)) dut4 (
    .CLK(clk), .RST(rst), .FrameData_I(frame_data_i), .RowSelect(row_select),
    .FrameValid_I(frame_valid_i),
`ifdef FRAME_DATA_PIPE_PARITY_EN
    .FrameParity_I(frame_parity_i), .ParityErr_O(perr4),
`endif
    .FrameData_O(data4), .FrameValid_O(vld4), .FrameCount_O(cnt4), .Busy_O(busy4)
  );

  frame_data_pipe #(.BroadcastEn(1'b1)) dutb (
    .CLK(clk), .RST(rst), .FrameData_I(frame_data_i), .RowSelect(row_select),
    .FrameValid_I(frame_valid_i),
`ifdef FRAME_DATA_PIPE_PARITY_EN
    .FrameParity_I(frame_parity_i), .ParityErr_O(perrb),
`endif
    .FrameData_O(datab), .FrameValid_O(vldb), .FrameCount_O(cntb), .Busy_O(busyb)
  );

  // ---------------- driver tasks ----------------
  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] d, input logic [4:0] sel, input logic v);
    frame_data_i  = d;
    row_select    = sel;
    frame_valid_i = v;
`ifdef FRAME_DATA_PIPE_PARITY_EN
    frame_parity_i = ^d;
`endif
  endtask

  task automatic idle();
    drive(32'h0, 5'd0, 1'b0);
  endtask

  task automatic apply_reset();
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    apply_reset();
    checks++; if (vld_o !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", vld_o); end
    checks++; if (data_o !== 32'h0) begin failures++; $display("FAIL reset_data got=%h exp=00000000", data_o); end
    checks++; if (cnt_o !== 16'h0) begin failures++; $display("FAIL reset_count got=%h exp=0000", cnt_o); end
    checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy_o); end
  endtask

  task automatic test_single_frame();
    apply_reset();
    drive(32'hDEADBEEF, 5'd1, 1'b1);
    tick();  // E0: accepted
    idle();
    checks++; if (busy_o !== 1'b1) begin failures++; $display("FAIL single_busy_e0 got=%0b exp=1", busy_o); end
    checks++; if (vld_o !== 1'b0) begin failures++; $display("FAIL single_valid_e0 got=%0b exp=0", vld_o); end
    tick();  // E1
    checks++; if (vld_o !== 1'b0) begin failures++; $display("FAIL single_valid_e1 got=%0b exp=0", vld_o); end
    tick();  // E2: delivered
    checks++; if (vld_o !== 1'b1) begin failures++; $display("FAIL single_valid_e2 got=%0b exp=1", vld_o); end
    checks++; if (data_o !== 32'hDEADBEEF) begin failures++; $display("FAIL single_data got=%h exp=deadbeef", data_o); end
    checks++; if (cnt_o !== 16'd1) begin failures++; $display("FAIL single_count got=%0d exp=1", cnt_o); end
    tick();  // E3: pulse over, word held
    checks++; if (vld_o !== 1'b0) begin failures++; $display("FAIL single_valid_e3 got=%0b exp=0", vld_o); end
    checks++; if (data_o !== 32'hDEADBEEF) begin failures++; $display("FAIL single_hold got=%h exp=deadbeef", data_o); end
    checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL single_busy_e3 got=%0b exp=0", busy_o); end
  endtask

  task automatic test_back_to_back();
    logic        exp_v;
    logic [15:0] exp_c;
    apply_reset();
    for (int cyc = 0; cyc < 14; cyc++) begin
      if (cyc < 8) drive(32'(cyc + 1), 5'd1, 1'b1);
      else idle();
      tick();
      exp_v = (cyc >= 4) && (cyc < 12);
      exp_c = (cyc < 4) ? 16'd0 : ((cyc >= 11) ? 16'd8 : 16'(cyc - 3));
      checks++;
      if (vld4 !== exp_v) begin failures++; $display("FAIL b2b_valid cyc=%0d got=%0b exp=%0b", cyc, vld4, exp_v); end
      if (exp_v) begin
        checks++;
        if (data4 !== 32'(cyc - 3)) begin failures++; $display("FAIL b2b_data cyc=%0d got=%h exp=%h", cyc, data4, 32'(cyc - 3)); end
      end
      checks++;
      if (cnt4 !== exp_c) begin failures++; $display("FAIL b2b_count cyc=%0d got=%0d exp=%0d", cyc, cnt4, exp_c); end
    end
  endtask

  task automatic test_bubbles();
    apply_reset();
    drive(32'hCAFEF00D, 5'd1, 1'b1);
    tick();
    idle();
    tick(); tick(); tick();
    checks++; if (data_o !== 32'hCAFEF00D) begin failures++; $display("FAIL bubble_setup got=%h exp=cafef00d", data_o); end
    drive(32'h11111111, 5'd2, 1'b1);  // wrong row
    tick();
    checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL bubble_busy_row got=%0b exp=0", busy_o); end
    drive(32'h22222222, 5'd1, 1'b0);  // right row, unqualified
    tick();
    checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL bubble_busy_unq got=%0b exp=0", busy_o); end
    idle();
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (vld_o !== 1'b0) begin failures++; $display("FAIL bubble_valid k=%0d got=%0b exp=0", k, vld_o); end
      checks++; if (data_o !== 32'hCAFEF00D) begin failures++; $display("FAIL bubble_data k=%0d got=%h exp=cafef00d", k, data_o); end
      checks++; if (cnt_o !== 16'd1) begin failures++; $display("FAIL bubble_count k=%0d got=%0d exp=1", k, cnt_o); end
    end
  endtask

  task automatic test_broadcast();
    apply_reset();
    drive(32'hA5A5A5A5, 5'h1F, 1'b1);
    tick();
    idle();
    tick(); tick();
    checks++; if (vldb !== 1'b1) begin failures++; $display("FAIL bcast_on_valid got=%0b exp=1", vldb); end
    checks++; if (datab !== 32'hA5A5A5A5) begin failures++; $display("FAIL bcast_on_data got=%h exp=a5a5a5a5", datab); end
    checks++; if (cntb !== 16'd1) begin failures++; $display("FAIL bcast_on_count got=%0d exp=1", cntb); end
    checks++; if (vld_o !== 1'b0) begin failures++; $display("FAIL bcast_off_valid got=%0b exp=0", vld_o); end
    checks++; if (data_o !== 32'h0) begin failures++; $display("FAIL bcast_off_data got=%h exp=00000000", data_o); end
    checks++; if (cnt_o !== 16'd0) begin failures++; $display("FAIL bcast_off_count got=%0d exp=0", cnt_o); end
  endtask

  task automatic test_reset_in_flight();
    apply_reset();
    drive(32'h12345678, 5'd1, 1'b1);
    tick();  // accepted
    idle();
    rst = 1'b1;
    tick();  // reset flushes it
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (vld_o !== 1'b0) begin failures++; $display("FAIL flush_valid k=%0d got=%0b exp=0", k, vld_o); end
      checks++; if (data_o !== 32'h0) begin failures++; $display("FAIL flush_data k=%0d got=%h exp=00000000", k, data_o); end
      checks++; if (cnt_o !== 16'd0) begin failures++; $display("FAIL flush_count k=%0d got=%0d exp=0", k, cnt_o); end
    end
  endtask

  task automatic test_saturation();
    apply_reset();
    for (int i = 0; i < 65534; i++) begin
      drive(32'(i), 5'd1, 1'b1);
      tick();
    end
    idle();
    tick(); tick(); tick();
    checks++; if (cnt_o !== 16'hFFFE) begin failures++; $display("FAIL sat_preload got=%h exp=fffe", cnt_o); end
    for (int i = 0; i < 3; i++) begin
      drive(32'h5A000000 + 32'(i), 5'd1, 1'b1);
      tick();
    end
    idle();
    tick(); tick(); tick();
    checks++; if (cnt_o !== 16'hFFFF) begin failures++; $display("FAIL sat_count got=%h exp=ffff", cnt_o); end
    checks++; if (data_o !== 32'h5A000002) begin failures++; $display("FAIL sat_last_data got=%h exp=5a000002", data_o); end
  endtask

`ifdef FRAME_DATA_PIPE_PARITY_EN
  task automatic test_parity();
    apply_reset();
    checks++; if (perr_o !== 1'b0) begin failures++; $display("FAIL parity_reset got=%0b exp=0", perr_o); end
    drive(32'h00000001, 5'd1, 1'b1);
    frame_parity_i = 1'b0;  // odd data with parity 0 is a bad frame
    tick();
    idle();
    checks++; if (perr_o !== 1'b1) begin failures++; $display("FAIL parity_set got=%0b exp=1", perr_o); end
    checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL parity_drop_busy got=%0b exp=0", busy_o); end
    tick(); tick();
    checks++; if (vld_o !== 1'b0) begin failures++; $display("FAIL parity_drop_valid got=%0b exp=0", vld_o); end
    drive(32'h00000003, 5'd1, 1'b1);
    frame_parity_i = 1'b0;
    tick();
    idle();
    tick(); tick();
    checks++; if (vld_o !== 1'b1) begin failures++; $display("FAIL parity_good_valid got=%0b exp=1", vld_o); end
    checks++; if (data_o !== 32'h3) begin failures++; $display("FAIL parity_good_data got=%h exp=00000003", data_o); end
    checks++; if (perr_o !== 1'b1) begin failures++; $display("FAIL parity_sticky got=%0b exp=1", perr_o); end
  endtask
`endif

  // ---------------- sequence and report ----------------
  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    idle();
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_bubbles();
    test_broadcast();
    test_reset_in_flight();
    test_saturation();
`ifdef FRAME_DATA_PIPE_PARITY_EN
    test_parity();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
